// File: rtl/usrt_pkg.sv
// Shared definitions for the USRT APB transfer sequencer: address codes, FSM states
// and status register bit positions.
package usrt_pkg;

  localparam logic [1:0] ADDR_STAT = 2'b00;
  localparam logic [1:0] ADDR_TX   = 2'b01;
  localparam logic [1:0] ADDR_RX   = 2'b10;
  localparam logic [1:0] ADDR_NONE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDone
  } usrt_state_e;

  localparam int unsigned STAT_TX_BUSY  = 0;
  localparam int unsigned STAT_RX_VALID = 1;
  localparam int unsigned STAT_TIMEOUT  = 2;

  // TX is write-only and RX is read-only; code 11 decodes to nothing.
  function automatic logic is_invalid(input logic [1:0] code, input logic write);
    return (code == ADDR_NONE) || ((code == ADDR_TX) && !write) ||
           ((code == ADDR_RX) && write);
  endfunction

endpackage

// File: rtl/usrt_wait_timer.sv
// Saturating wait-state counter; o_Expired is high once TIMEOUT not-ready cycles are counted.
module usrt_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam logic [7:0] Limit = 8'(TIMEOUT);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_Clear) begin
      count_d = '0;
    end else if (i_Enable && (count_q != Limit)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_Expired = (count_q == Limit);

endmodule

// File: rtl/usrt_apb_ctrl.sv
// APB transfer sequencer for the USRT: decodes the target, inserts wait states, issues
// load/ack strobes to the TX/RX cores and owns the control register.
module usrt_apb_ctrl
  import usrt_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Psel,
  input  logic              i_Penable,
  input  logic              i_Pwrite,
  input  logic [31:0]       i_Paddr,
  input  logic [DATA_W-1:0] i_Pwdata,
  output logic [DATA_W-1:0] o_Prdata,
  output logic              o_Pready,
  output logic              o_Pslverr,
  input  logic              i_Tx_Busy,
  output logic              o_Tx_Load,
  output logic [DATA_W-1:0] o_Tx_Data,
  input  logic              i_Rx_Valid,
  input  logic [DATA_W-1:0] i_Rx_Data,
  output logic              o_Rx_Ack,
  output logic [DATA_W-1:0] o_Ctrl
);

  usrt_state_e       state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic              tx_load_q, tx_load_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              rx_ack_q, rx_ack_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;

  logic              timer_clr, timer_en, expired;
  logic              ready, flag_set, flag_clr;
  logic [DATA_W-1:0] status_w;
  logic              unused_addr;

  assign unused_addr = ^i_Paddr[29:0];

  usrt_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (timer_clr),
    .i_Enable (timer_en),
    .o_Expired(expired)
  );

  always_comb begin
    status_w                = '0;
    status_w[STAT_TX_BUSY]  = i_Tx_Busy;
    status_w[STAT_RX_VALID] = i_Rx_Valid;
    status_w[STAT_TIMEOUT]  = flag_q;
    unique case (addr_q)
      ADDR_STAT: ready = 1'b1;
      ADDR_TX:   ready = !i_Tx_Busy;
      ADDR_RX:   ready = i_Rx_Valid;
      default:   ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    tx_load_d = 1'b0;
    tx_data_d = tx_data_q;
    rx_ack_d  = 1'b0;
    ctrl_d    = ctrl_q;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_Psel && !i_Penable) begin
          state_d = StSetup;
          addr_d  = i_Paddr[31:30];
          wr_d    = i_Pwrite;
          wdata_d = i_Pwdata;
        end
      end
      StSetup: begin
        if (!i_Psel) begin
          state_d = StIdle;
        end else if (i_Penable) begin
          state_d = StAccess;
        end
      end
      StAccess: begin
        timer_clr = 1'b0;
        if (!i_Psel || !i_Penable) begin
          state_d = StIdle;
        end else if (is_invalid(addr_q, wr_q)) begin
          state_d   = StDone;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else if (ready) begin
          state_d  = StDone;
          pready_d = 1'b1;
          unique case (addr_q)
            ADDR_TX: begin
              tx_load_d = 1'b1;
              tx_data_d = wdata_q;
            end
            ADDR_RX: begin
              rx_ack_d = 1'b1;
              prdata_d = i_Rx_Data;
            end
            default: begin
              if (wr_q) begin
                ctrl_d = wdata_q;
              end else begin
                prdata_d = status_w;
                flag_clr = 1'b1;
              end
            end
          endcase
        end else if (expired) begin
          state_d   = StDone;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          flag_set  = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    flag_d = flag_set | (flag_q & ~flag_clr);
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      flag_q    <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      tx_load_q <= 1'b0;
      tx_data_q <= '0;
      rx_ack_q  <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      flag_q    <= flag_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      tx_load_q <= tx_load_d;
      tx_data_q <= tx_data_d;
      rx_ack_q  <= rx_ack_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign o_Prdata  = prdata_q;
  assign o_Pready  = pready_q;
  assign o_Pslverr = pslverr_q;
  assign o_Tx_Load = tx_load_q;
  assign o_Tx_Data = tx_data_q;
  assign o_Rx_Ack  = rx_ack_q;
  assign o_Ctrl    = ctrl_q;

endmodule

// File: tb/tb_usrt_apb_ctrl.sv
// Bench for usrt_apb_ctrl: transaction-level model predicts every output each cycle,
// plus directed scenarios pinned with literal expectations.
module tb_usrt_apb_ctrl;
  import usrt_pkg::*;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr;
  logic [7:0]  pwdata, prdata, tx_data, rx_data, ctrl;
  logic        pready, pslverr, tx_busy, tx_load, rx_valid, rx_ack;

  always #5 clk = ~clk;

  usrt_apb_ctrl #(
    .DATA_W (8),
    .TIMEOUT(TMO)
  ) dut (
    .i_Clock   (clk),
    .i_Reset   (rst),
    .i_Psel    (psel),
    .i_Penable (penable),
    .i_Pwrite  (pwrite),
    .i_Paddr   (paddr),
    .i_Pwdata  (pwdata),
    .o_Prdata  (prdata),
    .o_Pready  (pready),
    .o_Pslverr (pslverr),
    .i_Tx_Busy (tx_busy),
    .o_Tx_Load (tx_load),
    .o_Tx_Data (tx_data),
    .i_Rx_Valid(rx_valid),
    .i_Rx_Data (rx_data),
    .o_Rx_Ack  (rx_ack),
    .o_Ctrl    (ctrl)
  );

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   tx_loads = 0;
  int   rx_acks = 0;

  // Expected outputs and the model's sticky timeout flag.
  logic [7:0] exp_prdata, exp_tx_data, exp_ctrl;
  logic       exp_pready, exp_pslverr, exp_tx_load, exp_rx_ack, m_tflag;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("prdata", prdata, exp_prdata);
      chk("pready", 8'(pready), 8'(exp_pready));
      chk("pslverr", 8'(pslverr), 8'(exp_pslverr));
      chk("tx_load", 8'(tx_load), 8'(exp_tx_load));
      chk("tx_data", tx_data, exp_tx_data);
      chk("rx_ack", 8'(rx_ack), 8'(exp_rx_ack));
      chk("ctrl", ctrl, exp_ctrl);
      if (tx_load === 1'b1) tx_loads++;
      if (rx_ack === 1'b1) rx_acks++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_prdata  = '0;
    exp_tx_data = '0;
    exp_ctrl    = '0;
    exp_pready  = 1'b0;
    exp_pslverr = 1'b0;
    exp_tx_load = 1'b0;
    exp_rx_ack  = 1'b0;
    m_tflag     = 1'b0;
  endtask

  task automatic drive_side(input logic [1:0] code, input logic rdy, input logic busy_o,
                            input logic valid_o);
    case (code)
      ADDR_TX: begin tx_busy = !rdy;   rx_valid = valid_o; end
      ADDR_RX: begin tx_busy = busy_o; rx_valid = rdy;     end
      default: begin tx_busy = busy_o; rx_valid = valid_o; end
    endcase
  endtask

  // One APB transfer. ready_at: ACCESS cycle (1-based) from which the target is ready,
  // 0 = never. abort_at: ACCESS cycle in which the master drops the transfer, 0 = never.
  task automatic xfer(input logic [1:0] code, input logic wr, input logic [7:0] wd,
                      input int ready_at, input int abort_at, input logic busy_o,
                      input logic valid_o, input logic [7:0] rxd);
    logic inval, rdy, done;
    inval   = (code == ADDR_NONE) || (code == ADDR_TX && !wr) || (code == ADDR_RX && wr);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = {code, 30'($urandom)};
    pwrite  = wr;
    pwdata  = wd;
    rx_data = rxd;
    drive_side(code, 1'b0, busy_o, valid_o);
    tick();
    penable = 1'b1;
    pwdata  = 8'($urandom);
    tick();
    done = 1'b0;
    for (int k = 1; !done; k++) begin
      if (abort_at == k) begin
        if ($urandom_range(0, 1) == 1) psel = 1'b0;
        else penable = 1'b0;
        tick();
        psel    = 1'b0;
        penable = 1'b0;
        done    = 1'b1;
      end else begin
        rdy = (ready_at != 0) && (k >= ready_at);
        drive_side(code, rdy, busy_o, valid_o);
        tick();
        if (inval) begin
          exp_pready = 1'b1; exp_pslverr = 1'b1; done = 1'b1;
        end else if (code == ADDR_STAT) begin
          exp_pready = 1'b1; done = 1'b1;
          if (wr) exp_ctrl = wd;
          else begin
            exp_prdata = {5'b0, m_tflag, valid_o, busy_o};
            m_tflag    = 1'b0;
          end
        end else if (rdy) begin
          exp_pready = 1'b1; done = 1'b1;
          if (code == ADDR_TX) begin
            exp_tx_load = 1'b1; exp_tx_data = wd;
          end else begin
            exp_rx_ack = 1'b1; exp_prdata = rxd;
          end
        end else if (k == int'(TMO) + 1) begin
          exp_pready = 1'b1; exp_pslverr = 1'b1; m_tflag = 1'b1; done = 1'b1;
        end
        if (done) begin
          tick();
          exp_pready  = 1'b0;
          exp_pslverr = 1'b0;
          exp_tx_load = 1'b0;
          exp_rx_ack  = 1'b0;
          psel        = 1'b0;
          penable     = 1'b0;
        end
      end
    end
    tick();
  endtask

  initial begin
    int n;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();
    #2 rst = 1'b0;
    #3;
    chk("rst_prdata", prdata, 8'h00);
    chk("rst_pready", 8'(pready), 8'h00);
    chk("rst_pslverr", 8'(pslverr), 8'h00);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_strobes", 8'({tx_load, rx_ack}), 8'h00);
    chk_en = 1'b1;
    @(posedge clk);
    #3 rst = 1'b1;
    tick();

    // Control write then status read.
    xfer(ADDR_STAT, 1'b1, 8'h5A, 1, 0, 1'b0, 1'b0, 8'h00);
    chk("t1_ctrl", ctrl, 8'h5A);
    xfer(ADDR_STAT, 1'b0, 8'h00, 1, 0, 1'b1, 1'b0, 8'h00);
    chk("t1_status", prdata, 8'h01);

    // TX write held off by busy for three ACCESS cycles.
    n = tx_loads;
    xfer(ADDR_TX, 1'b1, 8'hA5, 4, 0, 1'b0, 1'b0, 8'h00);
    chk("t2_txdata", tx_data, 8'hA5);
    chk("t2_loads", 8'(tx_loads - n), 8'd1);

    // RX timeout, then the sticky flag is read and cleared.
    n = rx_acks;
    xfer(ADDR_RX, 1'b0, 8'h00, 0, 0, 1'b0, 1'b0, 8'h99);
    chk("t3_acks", 8'(rx_acks - n), 8'd0);
    xfer(ADDR_STAT, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0, 8'h00);
    chk("t3_flag_set", prdata, 8'h04);
    xfer(ADDR_STAT, 1'b0, 8'h00, 1, 0, 1'b0, 1'b0, 8'h00);
    chk("t3_flag_clr", prdata, 8'h00);

    // RX becomes valid exactly when the counter reaches TIMEOUT.
    n = rx_acks;
    xfer(ADDR_RX, 1'b0, 8'h00, TMO + 1, 0, 1'b0, 1'b0, 8'h3C);
    chk("t4_rxdata", prdata, 8'h3C);
    chk("t4_acks", 8'(rx_acks - n), 8'd1);

    // Invalid accesses.
    xfer(ADDR_NONE, 1'b0, 8'h00, 1, 0, 1'b0, 1'b1, 8'h00);
    xfer(ADDR_NONE, 1'b1, 8'hFF, 1, 0, 1'b0, 1'b0, 8'h00);
    xfer(ADDR_TX, 1'b0, 8'h12, 1, 0, 1'b0, 1'b0, 8'h00);
    xfer(ADDR_RX, 1'b1, 8'h34, 1, 0, 1'b0, 1'b0, 8'h00);
    chk("t5_ctrl", ctrl, 8'h5A);

    // Master abort mid-ACCESS, then a protocol violation in IDLE.
    n = tx_loads;
    xfer(ADDR_TX, 1'b1, 8'h66, 0, 3, 1'b0, 1'b0, 8'h00);
    chk("t6_abort_loads", 8'(tx_loads - n), 8'd0);
    chk("t6_abort_txdata", tx_data, 8'hA5);
    psel = 1'b1; penable = 1'b1; paddr = 32'h0; pwrite = 1'b1; pwdata = 8'hEE;
    tick();
    tick();
    psel = 1'b0; penable = 1'b0;
    tick();
    chk("t6_viol_ctrl", ctrl, 8'h5A);

    // Reset during a TX wait.
    n = tx_loads;
    psel = 1'b1; penable = 1'b0; paddr = {ADDR_TX, 30'h0}; pwrite = 1'b1; pwdata = 8'h77;
    tx_busy = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    tick();
    tick();
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_ctrl", ctrl, 8'h00);
    chk("t6_rst_txdata", tx_data, 8'h00);
    chk("t6_rst_prdata", prdata, 8'h00);
    psel = 1'b0; penable = 1'b0; tx_busy = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_rst_loads", 8'(tx_loads - n), 8'd0);

    // Randomized transfers.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] code;
      int ra, ab;
      code = 2'($urandom_range(0, 3));
      ra   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 18));
      ab   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      xfer(code, 1'($urandom), 8'($urandom), ra, ab, 1'($urandom), 1'($urandom),
           8'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usrt_apb_ctrl.md
Name: usrt_apb_ctrl

Overview:
APB-style transfer sequencer for the USRT. It sits between the APB bus and the USRT core.
It decodes i_Paddr[31:30] to one of three targets: status/control, TX, RX.
It runs the SETUP/ACCESS handshake and inserts wait states until the target core side is ready. It aborts with PSLVERR on timeout or on an invalid address.
It issues single-cycle load/ack strobes to the TX and RX cores and owns the control register.

Parameters:
DATA_W, 8, width of Pwdata/Prdata, TX/RX data and the control register.
TIMEOUT, 15, maximum wait cycles in ACCESS before the transfer ends with error (legal range 1..255).

Ports:
i_Clock  in  1  system clock, rising edge
i_Reset  in  1  asynchronous, active-low reset
i_Psel  in  1  APB select
i_Penable  in  1  APB enable
i_Pwrite  in  1  1=write, 0=read
i_Paddr  in  32  address; only bits [31:30] decoded (00 status/ctrl, 01 TX, 10 RX, 11 invalid)
i_Pwdata  in  DATA_W  write data
o_Prdata  out  DATA_W  read data, valid while o_Pready=1
o_Pready  out  1  transfer complete, 1-cycle pulse
o_Pslverr  out  1  error qualifier, only meaningful with o_Pready
i_Tx_Busy  in  1  TX core cannot accept a byte
o_Tx_Load  out  1  1-cycle strobe: o_Tx_Data to be loaded
o_Tx_Data  out  DATA_W  byte to transmit
i_Rx_Valid  in  1  RX core holds an unread byte
i_Rx_Data  in  DATA_W  received byte
o_Rx_Ack  out  1  1-cycle strobe: byte consumed
o_Ctrl  out  DATA_W  control register (core enables, mode bits)

Behaviour:
- Reset (i_Reset=0, async): state IDLE, wait counter 0, timeout flag 0. Outputs o_Prdata, o_Pready, o_Pslverr, o_Tx_Load, o_Tx_Data, o_Rx_Ack, o_Ctrl all 0. A reset mid-transfer drops the transfer with no strobe.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Psel=1 and Penable=0 -> SETUP. Latch the address code, Pwrite and Pwdata.
  - Psel=1 and Penable=1 in IDLE is a protocol violation: ignore it and stay IDLE.
- SETUP:
  - Penable=1 -> ACCESS, with the wait counter cleared.
  - Psel=0 -> IDLE.
  - Otherwise stay in SETUP.
- ACCESS, evaluated every cycle with the "ready" condition below:
  - ready: status/ctrl always; TX write when i_Tx_Busy=0; RX read when i_Rx_Valid=1.
  - Invalid combinations: address 11, TX read, RX write. These complete immediately with error.
  - Ready -> DONE. On the same edge set o_Pready=1 and perform the side effect:
    - TX: o_Tx_Load=1, o_Tx_Data=latched Pwdata.
    - RX: o_Rx_Ack=1, o_Prdata=i_Rx_Data.
    - ctrl write: o_Ctrl=latched Pwdata.
    - status read: o_Prdata={zeros, timeout_flag, i_Rx_Valid, i_Tx_Busy} (bits [2:0]).
  - Not ready: increment the counter. When the counter reaches TIMEOUT -> DONE with o_Pready=1, o_Pslverr=1, no side effect, timeout_flag set.
  - Readiness is checked before timeout. Ready on the same cycle the count hits TIMEOUT is a success.
  - Psel or Penable dropping in ACCESS -> abort to IDLE. No strobe, no Pready.
- DONE: o_Pready, o_Pslverr, o_Tx_Load and o_Rx_Ack return to 0 on the next edge -> IDLE. o_Prdata holds its value until the next read completes.
- Latency: best case Pready is asserted on the 2nd edge after Penable is sampled. The bus sees the setup cycle, the access cycle, and Pready one cycle later.
- timeout_flag: sticky; cleared by a successful status read. If set and clear coincide, set wins.
- Strobes never overlap and never exceed 1 cycle. Back-to-back transfers are allowed, with a minimum 1 IDLE cycle between them.

Decomposition:
- Shared package usrt_pkg:
  - address codes ADDR_STAT=2'b00, ADDR_TX=2'b01, ADDR_RX=2'b10, ADDR_NONE=2'b11
  - FSM state encoding
  - status bit indices
- One natural sub-module: usrt_wait_timer. It provides the saturating wait counter with clear/enable inputs and an expired output at TIMEOUT.

Test Plan:
1. Ctrl write then status read: write 0x5A to addr 00 -> o_Ctrl=0x5A after Pready; status read with Tx_Busy=1, Rx_Valid=0 -> Prdata=0x01, Pslverr=0.
2. TX write with wait: i_Tx_Busy=1 for 3 ACCESS cycles, then 0; write 0xA5 to addr 01 -> exactly one o_Tx_Load pulse with o_Tx_Data=0xA5, Pready 1 cycle after Busy falls.
3. RX timeout: read addr 10 with i_Rx_Valid held 0, TIMEOUT=15 -> Pready+Pslverr after 15 wait cycles, no o_Rx_Ack; the next status read returns bit2=1, and a following status read returns bit2=0.
4. RX success on boundary: i_Rx_Valid rises on the cycle the counter reaches TIMEOUT, i_Rx_Data=0x3C -> Pslverr=0, Prdata=0x3C, one o_Rx_Ack pulse.
5. Invalid access: addr 11 (read and write), TX read, RX write -> each completes with Pready+Pslverr on the first ACCESS evaluation, and o_Ctrl is unchanged.
6. Abort/reset: drop Psel mid-ACCESS -> no Pready or strobes, return to IDLE; assert i_Reset=0 during a TX wait -> all outputs 0 immediately and no Tx_Load after release.
